// File: rtl/mem_wb_stage.sv
// Memory-stage responder and MEM/WB pipeline register for the RV32 core.
// Services word/byte loads and stores from an internal RAM, with optional wait-states that stall upstream.
module mem_wb_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [4:0]            RdM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    input  logic                  RegWriteM,
    input  logic                  ResultSrcM,
    input  logic                  MemWriteM,
    input  logic                  addr_modeM,
    output logic                  StallM,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic [DATA_WIDTH-1:0] ALUResultW,
    output logic [4:0]            RdW,
    output logic [DATA_WIDTH-1:0] PCPlus4W,
    output logic                  RegWriteW,
    output logic                  ResultSrcW
);
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic                    access;
    logic                    stall;
    logic                    commit;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [4:0]              lane_sh;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   rd_data_d;
    logic                    regwrite_d;
    logic                    unused_addr_bits;

    logic [DATA_WIDTH-1:0]   mem_q [2**DEPTH_LOG2];

    logic [DATA_WIDTH-1:0]   read_data_q;
    logic [DATA_WIDTH-1:0]   alu_result_q;
    logic [4:0]              rd_q;
    logic [DATA_WIDTH-1:0]   pc_plus4_q;
    logic                    reg_write_q;
    logic                    result_src_q;

    assign access  = MemWriteM | (ResultSrcM & RegWriteM);
    assign idx     = ALUResultM[DEPTH_LOG2+1:2];
    assign lane_sh = {ALUResultM[1:0], 3'b000};
    // Address bits above the RAM window alias onto the same words.
    assign unused_addr_bits = ^ALUResultM[DATA_WIDTH-1:DEPTH_LOG2+2];

    always_comb begin
        stall = 1'b0;
        if (WAIT_STATES != 0) begin
            if (state_q == IDLE) stall = access;
            else                 stall = (cnt_q != '0);
        end
    end

    assign StallM     = stall;
    assign commit     = MemWriteM & ~stall & ~rst;
    assign regwrite_d = RegWriteM & ~stall;

    // Read sees the pre-write word, so a same-cycle store does not bypass into the load.
    assign rd_word   = mem_q[idx];
    assign rd_data_d = addr_modeM ? {{(DATA_WIDTH-8){1'b0}}, rd_word[lane_sh +: 8]} : rd_word;

    always_ff @(posedge clk) begin
        if (commit) begin
            if (addr_modeM) mem_q[idx][lane_sh +: 8] <= WriteDataM[7:0];
            else            mem_q[idx]               <= WriteDataM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (stall) begin
                    state_q <= WAIT;
                    cnt_q   <= CNT_INIT;
                end
                WAIT: begin
                    if (cnt_q == '0) state_q <= IDLE;
                    else             cnt_q   <= cnt_q - CW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_q  <= '0;
            alu_result_q <= '0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
            reg_write_q  <= 1'b0;
            result_src_q <= 1'b0;
        end else begin
            read_data_q  <= rd_data_d;
            alu_result_q <= ALUResultM;
            rd_q         <= RdM;
            pc_plus4_q   <= PCPlus4M;
            reg_write_q  <= regwrite_d;
            result_src_q <= ResultSrcM;
        end
    end

    assign ReadDataW  = read_data_q;
    assign ALUResultW = alu_result_q;
    assign RdW        = rd_q;
    assign PCPlus4W   = pc_plus4_q;
    assign RegWriteW  = reg_write_q;
    assign ResultSrcW = result_src_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: four instances with WAIT_STATES 0..3, each tracked by a
// per-cycle reference model plus literal checks on hand-computed values.
module tb_mem_wb_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v [4];
    logic [31:0] alu_v [4];
    logic [31:0] wd_v  [4];
    logic [4:0]  rd_v  [4];
    logic [31:0] pc_v  [4];
    logic        rw_v  [4];
    logic        rs_v  [4];
    logic        mw_v  [4];
    logic        am_v  [4];

    logic        stall_o [4];
    logic [31:0] rdata_o [4];
    logic [31:0] alu_o   [4];
    logic [4:0]  rd_o    [4];
    logic [31:0] pc_o    [4];
    logic        rw_o    [4];
    logic        rs_o    [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_wb_stage #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .WAIT_STATES(g)) u_dut (
            .clk(clk), .rst(rst_v[g]),
            .ALUResultM(alu_v[g]), .WriteDataM(wd_v[g]), .RdM(rd_v[g]), .PCPlus4M(pc_v[g]),
            .RegWriteM(rw_v[g]), .ResultSrcM(rs_v[g]), .MemWriteM(mw_v[g]), .addr_modeM(am_v[g]),
            .StallM(stall_o[g]), .ReadDataW(rdata_o[g]), .ALUResultW(alu_o[g]), .RdW(rd_o[g]),
            .PCPlus4W(pc_o[g]), .RegWriteW(rw_o[g]), .ResultSrcW(rs_o[g])
        );
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string n, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%h want=%h", n, d, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mm    [4][1024];
    bit          known [4][1024];
    int          busy  [4];
    bit          st_e  [4];
    bit          ev_full [4];
    bit          ev_rw   [4];
    bit          rd_known[4];
    logic [31:0] e_rdata [4];
    logic [31:0] e_alu   [4];
    logic [4:0]  e_rd    [4];
    logic [31:0] e_pc    [4];
    logic        e_rw    [4];
    logic        e_rs    [4];
    bit          started = 0;

    initial begin
        for (int d = 0; d < 4; d++) begin
            busy[d] = 0; ev_full[d] = 0; ev_rw[d] = 0;
            for (int i = 0; i < 1024; i++) known[d][i] = 0;
        end
        forever begin
            @(negedge clk); #3;
            for (int d = 0; d < 4; d++) begin
                bit acc;
                if (ev_full[d]) begin
                    if (rd_known[d]) chk("ReadDataW", d, rdata_o[d], e_rdata[d]);
                    chk("ALUResultW", d, alu_o[d], e_alu[d]);
                    chk("RdW", d, {27'd0, rd_o[d]}, {27'd0, e_rd[d]});
                    chk("PCPlus4W", d, pc_o[d], e_pc[d]);
                    chk("ResultSrcW", d, {31'd0, rs_o[d]}, {31'd0, e_rs[d]});
                end
                if (ev_rw[d]) chk("RegWriteW", d, {31'd0, rw_o[d]}, {31'd0, e_rw[d]});
                // A memory op must spend d extra cycles waiting before it completes.
                acc = mw_v[d] | (rs_v[d] & rw_v[d]);
                st_e[d] = (d > 0) && acc && (busy[d] < d);
                if (started) chk("StallM", d, {31'd0, stall_o[d]}, {31'd0, st_e[d]});
            end
            @(posedge clk);
            for (int d = 0; d < 4; d++) begin
                int   w;
                int   sh;
                logic [31:0] word;
                w  = int'(alu_v[d][11:2]);
                sh = 8 * int'(alu_v[d][1:0]);
                if (rst_v[d]) begin
                    busy[d] = 0; ev_full[d] = 1; ev_rw[d] = 1; rd_known[d] = 1;
                    e_rdata[d] = 0; e_alu[d] = 0; e_rd[d] = 0; e_pc[d] = 0; e_rw[d] = 0; e_rs[d] = 0;
                end else if (st_e[d]) begin
                    busy[d]++; ev_full[d] = 0; ev_rw[d] = 1; e_rw[d] = 0;
                end else begin
                    busy[d] = 0; ev_full[d] = 1; ev_rw[d] = 1;
                    word = mm[d][w];
                    rd_known[d] = known[d][w];
                    e_rdata[d] = am_v[d] ? ((word >> sh) & 32'hFF) : word;
                    if (mw_v[d]) begin
                        if (am_v[d]) begin
                            word = (word & ~(32'hFF << sh)) | ({24'd0, wd_v[d][7:0]} << sh);
                            mm[d][w] = word;
                        end else begin
                            mm[d][w] = wd_v[d];
                            known[d][w] = 1;
                        end
                    end
                    e_alu[d] = alu_v[d]; e_rd[d] = rd_v[d]; e_pc[d] = pc_v[d];
                    e_rw[d] = rw_v[d];   e_rs[d] = rs_v[d];
                end
            end
            started = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int d, input logic rw, input logic rs, input logic mw, input logic am,
                         input logic [31:0] a, input logic [31:0] wdat, input logic [4:0] r);
        rw_v[d] = rw; rs_v[d] = rs; mw_v[d] = mw; am_v[d] = am;
        alu_v[d] = a; wd_v[d] = wdat; rd_v[d] = r; pc_v[d] = a + 32'h100;
    endtask

    // Drive at a falling edge and hold through the d wait-state cycles.
    task automatic issue(input int d, input logic rw, input logic rs, input logic mw, input logic am,
                         input logic [31:0] a, input logic [31:0] wdat, input logic [4:0] r);
        @(negedge clk);
        drive(d, rw, rs, mw, am, a, wdat, r);
        repeat (d) @(negedge clk);
    endtask

    task automatic nop(input int d);
        @(negedge clk);
        drive(d, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            rst_v[d] = 1'b1;
            drive(d, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) rst_v[d] = 1'b0;
        #1;
        chk("reset ReadDataW", 0, rdata_o[0], 32'h0);
        chk("reset RegWriteW", 3, {31'd0, rw_o[3]}, 32'h0);
        chk("reset StallM", 3, {31'd0, stall_o[3]}, 32'h0);

        // Single-cycle word store then load
        issue(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
        issue(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd5);
        nop(0); #1;
        chk("ws0 word load", 0, rdata_o[0], 32'hDEADBEEF);
        chk("ws0 RegWriteW", 0, {31'd0, rw_o[0]}, 32'h1);
        chk("ws0 RdW", 0, {27'd0, rd_o[0]}, 32'd5);

        // Byte lane store and loads
        issue(0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12, 32'h123456AA, 5'd0);
        issue(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd6);
        nop(0); #1;
        chk("byte merge", 0, rdata_o[0], 32'hDEAABEEF);
        issue(0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h13, 32'h0, 5'd7);
        nop(0); #1;
        chk("byte load zext", 0, rdata_o[0], 32'h000000DE);

        // Address aliasing and ignored low bits in word mode
        issue(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1004, 32'h11111111, 5'd0);
        issue(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 5'd8);
        nop(0); #1;
        chk("wrap load", 0, rdata_o[0], 32'h11111111);
        issue(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h6, 32'h0, 5'd9);
        nop(0); #1;
        chk("unaligned word load", 0, rdata_o[0], 32'h11111111);

        // Two wait-states: load then plain ALU op
        issue(2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0BADF00D, 5'd0);
        @(negedge clk);
        drive(2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd3);
        #1 chk("ws2 stall c1", 2, {31'd0, stall_o[2]}, 32'h1);
        @(negedge clk); #1;
        chk("ws2 stall c2", 2, {31'd0, stall_o[2]}, 32'h1);
        chk("ws2 bubble c2", 2, {31'd0, rw_o[2]}, 32'h0);
        @(negedge clk); #1;
        chk("ws2 stall c3", 2, {31'd0, stall_o[2]}, 32'h0);
        chk("ws2 bubble c3", 2, {31'd0, rw_o[2]}, 32'h0);
        @(negedge clk);
        drive(2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h5, 32'h0, 5'd4);
        #1;
        chk("ws2 load data", 2, rdata_o[2], 32'h0BADF00D);
        chk("ws2 load RegWriteW", 2, {31'd0, rw_o[2]}, 32'h1);
        chk("ws2 alu no stall", 2, {31'd0, stall_o[2]}, 32'h0);
        nop(2); #1;
        chk("ws2 alu passthru", 2, alu_o[2], 32'h5);
        chk("ws2 alu RdW", 2, {27'd0, rd_o[2]}, 32'd4);

        // Reset in the middle of a three-wait-state store
        issue(3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'hA5A5A5A5, 5'd0);
        @(negedge clk);
        drive(3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h12345678, 5'd0);
        @(negedge clk);
        rst_v[3] = 1'b1;
        @(negedge clk);
        rst_v[3] = 1'b0;
        drive(3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        chk("rst StallM", 3, {31'd0, stall_o[3]}, 32'h0);
        chk("rst ALUResultW", 3, alu_o[3], 32'h0);
        chk("rst PCPlus4W", 3, pc_o[3], 32'h0);
        issue(3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 5'd2);
        nop(3); #1;
        chk("aborted store", 3, rdata_o[3], 32'hA5A5A5A5);

        // Back-to-back store/load with one wait-state
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'hCAFEF00D, 5'd0);
        #1 chk("b2b stall 1", 1, {31'd0, stall_o[1]}, 32'h1);
        @(negedge clk); #1 chk("b2b stall 2", 1, {31'd0, stall_o[1]}, 32'h0);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 5'd11);
        #1 chk("b2b stall 3", 1, {31'd0, stall_o[1]}, 32'h1);
        @(negedge clk); #1 chk("b2b stall 4", 1, {31'd0, stall_o[1]}, 32'h0);
        nop(1); #1;
        chk("b2b load", 1, rdata_o[1], 32'hCAFEF00D);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-stage responder and MEM/WB pipeline register for the pipelined RV32 core.
- Consumes the MEM-stage bundle produced by the EX/MEM register and services loads and stores against an internal word-addressed data RAM.
- Optional wait-states emulate slow memory; during them the block stalls the upstream pipeline.
- Delivers the WB-stage bundle (read data, ALU result, Rd, PC+4, controls).

Parameters:
- DATA_WIDTH, 32, data/address width
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (default 1024 words)
- WAIT_STATES, 0, extra cycles per memory access (0 = single-cycle)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- ALUResultM  in  DATA_WIDTH  byte address for loads/stores; passthrough result
- WriteDataM  in  DATA_WIDTH  store data
- RdM  in  5  destination register
- PCPlus4M  in  DATA_WIDTH  link value for jumps
- RegWriteM  in  1  instruction writes rd
- ResultSrcM  in  1  1 = load (result from memory)
- MemWriteM  in  1  store
- addr_modeM  in  1  0 = word access, 1 = byte access
- StallM  out  1  hold IF..MEM registers stable this cycle
- ReadDataW  out  DATA_WIDTH  load data (registered)
- ALUResultW  out  DATA_WIDTH  registered ALUResultM
- RdW  out  5  registered RdM
- PCPlus4W  out  DATA_WIDTH  registered PCPlus4M
- RegWriteW  out  1  registered RegWriteM (0 on bubble)
- ResultSrcW  out  1  registered ResultSrcM

Behaviour:
- Access definitions:
  - access = MemWriteM | (ResultSrcM & RegWriteM).
  - Word index = ALUResultM[DEPTH_LOG2+1:2]; higher address bits are ignored, so addresses alias modulo 4*2^DEPTH_LOG2.
- Word mode (addr_modeM=0):
  - ALUResultM[1:0] is ignored (forced aligned).
  - Store writes all 4 bytes.
  - Load returns the full word.
- Byte mode (addr_modeM=1):
  - Byte lane = ALUResultM[1:0], little-endian.
  - Store writes WriteDataM[7:0] to that lane only; other lanes are untouched.
  - Load returns {24'b0, lane byte} (zero-extended).
- Load and store together: store wins; ReadDataW gets the pre-write contents (read-before-write).
- FSM states IDLE and WAIT, with down-counter cnt of width clog2(WAIT_STATES+1):
  - WAIT_STATES=0: FSM stays in IDLE; StallM is constantly 0. Every cycle the W registers load the M inputs, ReadDataW loads the RAM read, and a store commits at the same edge. Latency is 1 cycle, identical to a plain pipeline register.
  - WAIT_STATES>0, IDLE with access=1: StallM=1 combinationally. On the edge, go to WAIT with cnt=WAIT_STATES-1 and load RegWriteW=0 (bubble). Do not commit the store.
  - WAIT with cnt!=0: StallM=1, cnt decrements, RegWriteW=0 bubble each edge.
  - WAIT with cnt==0: StallM=0. On this edge the store commits, or ReadDataW captures the load. The W registers load the M bundle, and the FSM returns to IDLE.
  - IDLE with access=0: StallM=0; W registers load normally.
  - An access therefore occupies WAIT_STATES+1 cycles, and StallM is high for exactly WAIT_STATES cycles.
- Stall contract:
  - Upstream holds all M inputs stable while StallM=1.
  - If inputs change mid-WAIT, the values present in the completion cycle are used.
- Back-to-back accesses: after completion the FSM is in IDLE. A new access in the next cycle stalls again; there is no idle gap beyond the FSM.
- Reset:
  - All W outputs are 0, FSM is IDLE, cnt is 0, StallM is 0 in the cycle after reset.
  - RAM contents are not reset.
  - Reset during WAIT aborts the access; a pending store is never committed.
- Bubble handling: a non-access instruction with RegWriteM=0 passes through with RegWriteW=0. ReadDataW in that case is don't-care but must still be the registered RAM read of the current address.

Test Plan:
- WAIT_STATES=0, word store then load:
  - Store 0xDEADBEEF to 0x10, then load 0x10.
  - Expect ReadDataW=0xDEADBEEF one cycle after the load, RegWriteW=1, RdW matches, StallM=0 throughout.
- Byte store/load on word 0x10=0xDEADBEEF:
  - Byte store 0xAA to 0x12; word load 0x10 -> 0xDEAABEEF.
  - Byte load 0x13 -> 0x000000DE.
- WAIT_STATES=2 load:
  - StallM=1 for exactly 2 cycles and RegWriteW=0 during them.
  - ReadDataW valid with RegWriteW=1 on the 3rd edge.
  - A non-memory ALU op (RegWriteM=1, MemWriteM=0, ResultSrcM=0, ALUResultM=0x5) passes with no stall: ALUResultW=0x5 next cycle.
- Reset mid-WAIT:
  - WAIT_STATES=3, store 0x12345678 to 0x20; assert rst in the 2nd stall cycle.
  - Outputs go to 0 and StallM=0; a later load of 0x20 returns the prior value, not 0x12345678.
- Address wrap:
  - DEPTH_LOG2=10, store 0x11111111 to 0x0000_1004; load 0x0000_0004 -> 0x11111111.
  - Word load from 0x0000_0006 returns the same word (low bits ignored).
- Back-to-back, WAIT_STATES=1:
  - Store 0xCAFEF00D to 0x40 immediately followed by load 0x40.
  - StallM pattern 1,0,1,0; load returns 0xCAFEF00D.
